sha2_multiblock_core: RTL and testbench
=======================================

Name: sha2_multiblock_core

Overview:
- Parametrised successor of the single-block SHA-256 compression unit.
- Hashes multi-block messages by chaining H across blocks.
- Supports SHA-256 and SHA-224 modes, with 1/2/4/8 rounds per clock.
- Uses a valid/ready block input and a valid/ready digest output. Sits between the message padder (upstream) and the digest consumer (downstream). Padding is done upstream.

Parameters:
- ROUNDS_PER_CYCLE, 1, compression rounds evaluated per clock. Legal values: 1, 2, 4, 8. Any other value is an elaboration error.
- SUPPORT_224, 1, when 0 the mode_224 input is ignored and the core is SHA-256 only.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- block_valid  in  1  upstream presents a 512-bit padded block
- block_ready  out  1  core can accept a block this cycle
- block  in  512  message block, word 0 in bits [511:480]
- block_first  in  1  block starts a new message; H is loaded from the IV
- block_last  in  1  block ends the message; digest is produced after it
- mode_224  in  1  SHA-224 select; sampled only on an accepted first block
- digest  out  256  final hash; in SHA-224 mode = {H0..H6, 32'h0}
- digest_valid  out  1  digest is stable and valid
- digest_ready  in  1  downstream consumes the digest
- busy  out  1  high in ROUND or UPDATE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE; block_ready=1; digest_valid=0; busy=0.
  - digest=0; H0..H7=0; a..h=0; round counter=0.
  - chain_valid=0; mode register=0.
- Reset mid-operation: any in-progress hash is abandoned, and a pending digest is dropped.
- States: IDLE, ROUND, UPDATE, DONE.
- IDLE:
  - block_ready=1.
  - Accept when block_valid&&block_ready.
  - Latch block into a 16-word schedule window.
  - If block_first or !chain_valid: working vars and H are loaded from the IV selected by mode_224, and the mode is latched. Otherwise working vars = current H.
  - Latch block_last. Go to ROUND, counter=0.
- ROUND:
  - Each cycle performs ROUNDS_PER_CYCLE chained rounds on a..h.
  - Round t uses K[t] and W[t]. W[t] is the window head for t<16, else s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16].
  - The window shifts ROUNDS_PER_CYCLE words per cycle, and the counter adds ROUNDS_PER_CYCLE.
  - Leave for UPDATE after the cycle that computes round 63, i.e. after 64/ROUNDS_PER_CYCLE cycles.
- UPDATE:
  - Hi <= Hi + working var i, all sums mod 2^32; chain_valid <= 1.
  - If last: go to DONE, digest registered from the new H, digest_valid<=1.
  - If not last: go to IDLE.
- DONE:
  - digest_valid=1 and digest held stable; block_ready=0.
  - On digest_ready: digest_valid<=0, chain_valid<=0, go to IDLE.
- Latency, with the acceptance edge at T:
  - Round edges are T+1 .. T+64/R. The update edge is T+64/R+1.
  - For R=1, digest_valid is first seen high 65 cycles after T.
  - Throughput: one block per 64/R+2 cycles.
- Boundary conditions:
  - block_first=1 while chain_valid=1 restarts from the IV; the prior chain is discarded.
  - block_first&&block_last on the same block means a single-block message.
  - block_valid with block_ready=0: nothing is sampled, and upstream must hold its inputs.
  - mode_224 on non-first blocks is ignored.
  - digest_ready while not in DONE is ignored.
  - SUPPORT_224=0: the IV is always the SHA-256 IV and digest is full 256 bits.

Decomposition:
- Package sha2_pkg holds:
  - K[0:63] constant array.
  - SHA-256 IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
  - SHA-224 IV (c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4).
  - State enum.
  - Functions rotr, s0, s1, S0, S1, ch, maj.
- Sub-module sha2_round: combinational, one round. Inputs a..h, K, W; outputs next a..h. Instantiated ROUNDS_PER_CYCLE times in a generate chain.

Test Plan:
- "abc" single block, SHA-256, R=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. digest_valid first high 65 cycles after the accept edge.
- Empty message (block 80000000 followed by zeros), SHA-256, R=4 -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855. digest_valid 17 cycles after accept.
- "abc", mode_224=1, R=2 -> digest 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
- 56-char two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first, then last), R=8 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. No digest_valid after block 1.
- Hold digest_ready=0 for 20 cycles in DONE with block_valid=1 -> digest stable, block_ready=0. Then pulse digest_ready -> IDLE; the next "abc" hash is correct.
- Assert reset during ROUND of a two-block message -> next cycle all outputs at reset values. A subsequent "abc" with block_first=0 is still hashed from the IV and gives the correct digest.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared SHA-2 constants, the controller state type and the round/schedule
// helper functions used by the multi-block compression core.
package sha2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUND  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } sha2_state_e;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Element [0] is H0 / working variable a.
  localparam logic [7:0][31:0] IV_256 = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [7:0][31:0] IV_224 = {
    32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
    32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] S0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] S1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha2_multiblock_core_if.sv
// Block-in / digest-out bundle between the padder, the core and the consumer.
// Both channels are valid/ready: a transfer happens on a rising clock edge where
// valid and ready are both high; the sender holds its payload stable while
// valid is high and ready is low, and ready never depends combinationally on valid.
interface sha2_multiblock_core_if;
  logic         block_valid;
  logic         block_ready;
  logic [511:0] block;
  logic         block_first;
  logic         block_last;
  logic         mode_224;
  logic [255:0] digest;
  logic         digest_valid;
  logic         digest_ready;
  logic         busy;

  modport master (
    output block_valid, block, block_first, block_last, mode_224, digest_ready,
    input  block_ready, digest, digest_valid, busy
  );

  modport slave (
    input  block_valid, block, block_first, block_last, mode_224, digest_ready,
    output block_ready, digest, digest_valid, busy
  );
endinterface

// File: rtl/sha2_round.sv
// One combinational SHA-2 compression round; st[0] is a, st[7] is h.
module sha2_round
  import sha2_pkg::*;
(
  input  logic [7:0][31:0] st,
  input  logic [31:0]      k,
  input  logic [31:0]      w,
  output logic [7:0][31:0] st_next
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1 = st[7] + S1(st[4]) + ch(st[4], st[5], st[6]) + k + w;
    t2 = S0(st[0]) + maj(st[0], st[1], st[2]);
    st_next[0] = t1 + t2;
    st_next[1] = st[0];
    st_next[2] = st[1];
    st_next[3] = st[2];
    st_next[4] = st[3] + t1;
    st_next[5] = st[4];
    st_next[6] = st[5];
    st_next[7] = st[6];
  end

endmodule

// File: rtl/sha2_multiblock_core.sv
// Multi-block SHA-256/SHA-224 compression core: chains H across padded blocks
// and evaluates ROUNDS_PER_CYCLE rounds per clock.
module sha2_multiblock_core
  import sha2_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit SUPPORT_224      = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  sha2_multiblock_core_if.slave  bus,
  output sha2_state_e            dbg_state
);

  localparam int          R        = ROUNDS_PER_CYCLE;
  localparam logic [5:0]  STEP     = 6'(R);
  localparam logic [5:0]  LAST_CNT = 6'(64 - R);

  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
    $error("sha2_multiblock_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  sha2_state_e       state;
  logic [5:0]        rnd_cnt;
  logic [15:0][31:0] w_win;     // [0] is W[rnd_cnt]
  logic [7:0][31:0]  wv;        // working variables a..h
  logic [7:0][31:0]  h_reg;
  logic              last_q;
  logic              chain_valid;
  logic              mode_q;
  logic              block_ready_q;
  logic              digest_valid_q;
  logic              busy_q;
  logic [255:0]      digest_q;

  logic              mode_sel;
  logic [7:0][31:0]  iv;
  logic [7:0][31:0]  h_new;
  logic [255:0]      digest_next;
  logic [7:0][31:0]  st_fin;
  logic [15:0][31:0] win_fin;

  assign mode_sel = SUPPORT_224 & bus.mode_224;
  assign iv       = mode_sel ? IV_224 : IV_256;

  // Each stage consumes the window head and appends the next schedule word,
  // so after R stages the window is already shifted by R words.
  for (genvar j = 0; j < R; j++) begin : g_rnd
    logic [7:0][31:0]  st_in;
    logic [7:0][31:0]  st_out;
    logic [15:0][31:0] win_in;
    logic [15:0][31:0] win_out;
    logic [31:0]       w_new;

    if (j == 0) begin : g_head
      assign st_in  = wv;
      assign win_in = w_win;
    end else begin : g_link
      assign st_in  = g_rnd[j-1].st_out;
      assign win_in = g_rnd[j-1].win_out;
    end

    assign w_new   = s1(win_in[14]) + win_in[9] + s0(win_in[1]) + win_in[0];
    assign win_out = {w_new, win_in[15:1]};

    sha2_round u_round (
      .st      (st_in),
      .k       (K[rnd_cnt + 6'(j)]),
      .w       (win_in[0]),
      .st_next (st_out)
    );
  end

  assign st_fin  = g_rnd[R-1].st_out;
  assign win_fin = g_rnd[R-1].win_out;

  always_comb begin
    for (int i = 0; i < 8; i++) h_new[i] = h_reg[i] + wv[i];
  end

  always_comb begin
    digest_next = '0;
    for (int i = 0; i < 8; i++) digest_next[255 - 32*i -: 32] = h_new[i];
    if (SUPPORT_224 && mode_q) digest_next[31:0] = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      rnd_cnt        <= '0;
      w_win          <= '0;
      wv             <= '0;
      h_reg          <= '0;
      last_q         <= 1'b0;
      chain_valid    <= 1'b0;
      mode_q         <= 1'b0;
      block_ready_q  <= 1'b1;
      digest_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      digest_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.block_valid && block_ready_q) begin
            for (int i = 0; i < 16; i++) w_win[i] <= bus.block[511 - 32*i -: 32];
            // A fresh message, or a continuation with no live chain, restarts from the IV.
            if (bus.block_first || !chain_valid) begin
              wv     <= iv;
              h_reg  <= iv;
              mode_q <= mode_sel;
            end else begin
              wv <= h_reg;
            end
            last_q        <= bus.block_last;
            rnd_cnt       <= '0;
            block_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            state         <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          wv      <= st_fin;
          w_win   <= win_fin;
          rnd_cnt <= rnd_cnt + STEP;
          if (rnd_cnt == LAST_CNT) state <= ST_UPDATE;
        end
        ST_UPDATE: begin
          h_reg       <= h_new;
          chain_valid <= 1'b1;
          busy_q      <= 1'b0;
          if (last_q) begin
            digest_q       <= digest_next;
            digest_valid_q <= 1'b1;
            state          <= ST_DONE;
          end else begin
            block_ready_q <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (bus.digest_ready) begin
            digest_valid_q <= 1'b0;
            chain_valid    <= 1'b0;
            block_ready_q  <= 1'b1;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.block_ready  = block_ready_q;
  assign bus.digest_valid = digest_valid_q;
  assign bus.digest       = digest_q;
  assign bus.busy         = busy_q;
  assign dbg_state        = state;

endmodule

// File: tb/tb_sha2_multiblock_core.sv
// Bench for sha2_multiblock_core: four instances (R = 1, 2, 4, 8) share one
// block driver; a monitor pops expected digests/latencies when a digest appears.
module tb_sha2_multiblock_core;
  import sha2_pkg::*;

  logic clock;
  logic reset;

  logic         drv_valid;
  int           drv_sel;
  logic [511:0] drv_block;
  logic         drv_first;
  logic         drv_last;
  logic         drv_mode;
  logic [3:0]   dready;

  logic         rdy_v  [4];
  logic         dv_v   [4];
  logic         busy_v [4];
  logic [255:0] dig_v  [4];
  sha2_state_e  st_v   [4];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int           id;
    int           acc;
    int           lat;
    logic [255:0] dig;
  } exp_t;
  exp_t exp_q[$];
  logic prev_dv [4];

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
  localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    sha2_multiblock_core_if bus ();
    sha2_state_e st;

    assign bus.block_valid  = drv_valid && (drv_sel == k);
    assign bus.block        = drv_block;
    assign bus.block_first  = drv_first;
    assign bus.block_last   = drv_last;
    assign bus.mode_224     = drv_mode;
    assign bus.digest_ready = dready[k];
    assign rdy_v[k]  = bus.block_ready;
    assign dv_v[k]   = bus.digest_valid;
    assign busy_v[k] = bus.busy;
    assign dig_v[k]  = bus.digest;
    assign st_v[k]   = st;

    sha2_multiblock_core #(
      .ROUNDS_PER_CYCLE (1 << k),
      .SUPPORT_224      (1'b1)
    ) u_dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (st)
    );
  end

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_reset(input int k);
    chk("rst_block_ready", 256'(rdy_v[k]), 256'd1);
    chk("rst_digest_valid", 256'(dv_v[k]), 256'd0);
    chk("rst_busy", 256'(busy_v[k]), 256'd0);
    chk("rst_digest", dig_v[k], 256'd0);
    chk("rst_state", 256'(st_v[k]), 256'(ST_IDLE));
  endtask

  // Driver: present a block and hold it until the core accepts it.
  task automatic send_block(input int id, input logic [511:0] b, input logic f,
                            input logic l, input logic m, input logic push,
                            input logic [255:0] d);
    int n;
    exp_t e;
    @(negedge clock);
    drv_sel = id; drv_block = b; drv_first = f; drv_last = l; drv_mode = m;
    drv_valid = 1'b1;
    n = 0;
    while (!rdy_v[id] && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (!rdy_v[id]) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=block_ready_low required=accept dut=%0d", id);
      drv_valid = 1'b0;
      return;
    end
    if (push) begin
      e.id = id; e.acc = cyc + 1; e.lat = 64 / (1 << id) + 1; e.dig = d;
      exp_q.push_back(e);
    end
    @(negedge clock);
    drv_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
    repeat (3) @(negedge clock);
  endtask

  // Scoreboard monitor: compare on each rising digest_valid.
  always @(negedge clock) begin
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (dv_v[k] && !prev_dv[k]) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_digest actual=%h required=none dut=%0d", dig_v[k], k);
        end else begin
          e = exp_q.pop_front();
          chk("digest_dut_id", 256'(k), 256'(e.id));
          chk("digest_value", dig_v[k], e.dig);
          chk("digest_latency", 256'(cyc - e.acc), 256'(e.lat));
        end
      end
      prev_dv[k] = dv_v[k];
    end
  end

  initial begin
    int n;
    for (int k = 0; k < 4; k++) prev_dv[k] = 1'b0;
    drv_valid = 1'b0; drv_sel = 0; drv_block = '0;
    drv_first = 1'b0; drv_last = 1'b0; drv_mode = 1'b0;
    dready = 4'hf;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    for (int k = 0; k < 4; k++) check_reset(k);
    reset = 1'b0;

    // Single-block messages on different round widths
    send_block(0, BLK_ABC, 1'b1, 1'b1, 1'b0, 1'b1, D_ABC);
    wait_drain();
    send_block(2, BLK_EMPTY, 1'b1, 1'b1, 1'b0, 1'b1, D_EMPTY);
    wait_drain();
    send_block(1, BLK_ABC, 1'b1, 1'b1, 1'b1, 1'b1, D_ABC224);
    wait_drain();

    // Two-block message; mode_224 on the continuation block must be ignored
    send_block(3, BLK_TWO1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    send_block(3, BLK_TWO2, 1'b0, 1'b1, 1'b1, 1'b1, D_TWO);
    wait_drain();

    // block_first while a chain is live restarts from the IV
    send_block(2, BLK_TWO1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    send_block(2, BLK_ABC, 1'b1, 1'b1, 1'b0, 1'b1, D_ABC);
    wait_drain();

    // Back-pressure in DONE with a block waiting upstream
    dready[0] = 1'b0;
    send_block(0, BLK_ABC, 1'b1, 1'b1, 1'b0, 1'b1, D_ABC);
    n = 0;
    while (!dv_v[0] && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("hold_reached_done", 256'(dv_v[0]), 256'd1);
    drv_sel = 0; drv_block = BLK_ABC; drv_first = 1'b1; drv_last = 1'b1;
    drv_mode = 1'b0; drv_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("hold_digest", dig_v[0], D_ABC);
      chk("hold_digest_valid", 256'(dv_v[0]), 256'd1);
      chk("hold_block_ready", 256'(rdy_v[0]), 256'd0);
    end
    dready[0] = 1'b1;
    send_block(0, BLK_ABC, 1'b1, 1'b1, 1'b0, 1'b1, D_ABC);
    wait_drain();

    // Reset in the middle of a message, then a continuation-flagged block
    send_block(3, BLK_TWO1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clock);
    chk("mid_round_busy", 256'(busy_v[3]), 256'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset(3);
    send_block(3, BLK_ABC, 1'b0, 1'b1, 1'b0, 1'b1, D_ABC);
    wait_drain();

    chk("queue_empty", 256'(exp_q.size()), 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
